pu_msp430_trace_ctrl: RTL and testbench

//  Instruction-trace capture controller for the MSP430 debug path. Samples {pc, ir} on each

---
 rtl/pu_msp430_trace_ctrl.sv | 114 +++++++++++
 tb/tb_pu_msp430_trace_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_msp430_trace_ctrl.sv
// MSP430 instruction-trace capture: circular {pc,ir} buffer with arm/trigger/post/stop sequencing.
// Optional PU_MSP430_TRACE_IRQ_FILTER_EN excludes IRQ-entry decodes from capture and triggering.
module pu_msp430_trace_ctrl #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          mclk,
    input  logic          puc_rst_n,
    input  logic          decode,
    input  logic [15:0]   pc,
    input  logic [15:0]   ir,
    input  logic          irq_detect,
    input  logic          cfg_arm,
    input  logic          cfg_stop,
    input  logic          cfg_trig_en,
    input  logic [15:0]   cfg_trig_pc,
    input  logic [AW:0]   cfg_post_cnt,
    input  logic          rd_req,
    output logic          rd_ack,
    output logic [31:0]   rd_data,
    output logic          rd_empty,
    output logic [AW:0]   count,
    output logic          trig_hit,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t        st;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   post_rem;
    logic [31:0]   mem [DEPTH];

    logic          qd;
    logic          capturing;
    logic          stopping;
    logic          we;
    logic          hit;
    logic          rd_go;
    logic [AW-1:0] rd_idx;
    logic [AW:0]   cnt_inc;

`ifdef PU_MSP430_TRACE_IRQ_FILTER_EN
    assign qd = decode & ~irq_detect;
`else
    logic unused_irq;
    assign unused_irq = irq_detect;
    assign qd = decode;
`endif

    assign capturing = (st == S_ARMED) || (st == S_POST);
    assign stopping  = cfg_stop & capturing;
    assign we        = qd & capturing & ~cfg_arm & ~stopping;
    assign hit       = cfg_trig_en && (pc == cfg_trig_pc);
    assign rd_idx    = wr_ptr - count[AW-1:0];
    assign cnt_inc   = (count == FULL) ? count : count + 1'b1;
    assign rd_go     = ~cfg_arm & (st == S_DONE) & rd_req & ~rd_ack
                     & (count != '0);
    assign rd_empty  = (count == '0);
    assign state     = st;

    // Trace RAM is intentionally unreset; count alone defines validity.
    always_ff @(posedge mclk) begin
        if (we)
            mem[wr_ptr] <= {pc, ir};
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            st       <= S_IDLE;
            wr_ptr   <= '0;
            count    <= '0;
            post_rem <= '0;
            trig_hit <= 1'b0;
            rd_ack   <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_ack <= 1'b0;
            if (cfg_arm) begin
                st       <= S_ARMED;
                wr_ptr   <= '0;
                count    <= '0;
                post_rem <= '0;
                trig_hit <= 1'b0;
            end else if (stopping) begin
                st <= S_DONE;
            end else if (we) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= cnt_inc;
                if (st == S_ARMED && hit) begin
                    trig_hit <= 1'b1;
                    post_rem <= cfg_post_cnt;
                    st       <= (cfg_post_cnt == '0) ? S_DONE : S_POST;
                end else if (st == S_POST) begin
                    post_rem <= post_rem - 1'b1;
                    if (post_rem == (AW+1)'(1))
                        st <= S_DONE;
                end
            end else if (rd_go) begin
                rd_ack  <= 1'b1;
                rd_data <= mem[rd_idx];
                count   <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pu_msp430_trace_ctrl.sv
// Scoreboard bench for pu_msp430_trace_ctrl: queue-based trace model plus random stimulus.
module tb_pu_msp430_trace_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          mclk = 1'b0;
    logic          puc_rst_n = 1'b0;
    logic          decode = 1'b0;
    logic [15:0]   pc = '0;
    logic [15:0]   ir = '0;
    logic          irq_detect = 1'b0;
    logic          cfg_arm = 1'b0;
    logic          cfg_stop = 1'b0;
    logic          cfg_trig_en = 1'b0;
    logic [15:0]   cfg_trig_pc = '0;
    logic [AW:0]   cfg_post_cnt = '0;
    logic          rd_req = 1'b0;
    logic          rd_ack;
    logic [31:0]   rd_data;
    logic          rd_empty;
    logic [AW:0]   count;
    logic          trig_hit;
    logic [1:0]    state;

    pu_msp430_trace_ctrl #(.DEPTH(DEPTH)) dut (
        .mclk(mclk), .puc_rst_n(puc_rst_n), .decode(decode), .pc(pc), .ir(ir),
        .irq_detect(irq_detect), .cfg_arm(cfg_arm), .cfg_stop(cfg_stop),
        .cfg_trig_en(cfg_trig_en), .cfg_trig_pc(cfg_trig_pc),
        .cfg_post_cnt(cfg_post_cnt), .rd_req(rd_req), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_empty(rd_empty), .count(count),
        .trig_hit(trig_hit), .state(state)
    );

    always #5 mclk = ~mclk;

    int          total = 0;
    int          bad = 0;
    int          mst = 0;
    logic [31:0] mbuf[$];
    bit          mtrig = 0;
    int          mpost = 0;
    bit          mack = 0;
    logic [31:0] expq[$];
    logic [31:0] last_rd = '0;
    bit          prev_ack = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mst = 0; mbuf.delete(); mtrig = 0; mpost = 0; mack = 0; expq.delete();
    endtask

    task automatic step(input bit dec, input logic [15:0] p, input logic [15:0] i,
                        input bit irq, input bit arm, input bit stop, input bit rq);
        bit qd;
        bit nack;
        @(negedge mclk);
        decode = dec; pc = p; ir = i; irq_detect = irq;
        cfg_arm = arm; cfg_stop = stop; rd_req = rq;
`ifdef PU_MSP430_TRACE_IRQ_FILTER_EN
        qd = dec && !irq;
`else
        qd = dec;
`endif
        nack = 0;
        if (arm) begin
            mst = 1; mbuf.delete(); mtrig = 0; mpost = 0;
        end else if (stop && (mst == 1 || mst == 2)) begin
            mst = 3;
        end else if ((mst == 1 || mst == 2) && qd) begin
            mbuf.push_back({p, i});
            if (mbuf.size() > DEPTH) void'(mbuf.pop_front());
            if (mst == 1) begin
                if (cfg_trig_en && p == cfg_trig_pc) begin
                    mtrig = 1;
                    mpost = int'(cfg_post_cnt);
                    mst = (mpost == 0) ? 3 : 2;
                end
            end else begin
                mpost--;
                if (mpost == 0) mst = 3;
            end
        end else if (mst == 3 && rq && !mack && mbuf.size() > 0) begin
            expq.push_back(mbuf.pop_front());
            nack = 1;
        end
        mack = nack;
        @(posedge mclk);
        #1;
        chk("state", 32'(state), 32'(mst));
        chk("count", 32'(count), 32'(mbuf.size()));
        chk("trig_hit", 32'(trig_hit), 32'(mtrig));
        chk("rd_empty", 32'(rd_empty), 32'(mbuf.size() == 0));
        chk("rd_ack", 32'(rd_ack), 32'(mack));
    endtask

    task automatic idle_step();
        step(0, 16'h0, 16'h0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        step(0, 16'h0, 16'h0, 0, 0, 1, 0);
        for (int k = 0; k < 2 * DEPTH + 4 && mbuf.size() > 0; k++)
            step(0, 16'h0, 16'h0, 0, 0, 0, 1);
        if (mbuf.size() > 0) begin
            total++; bad++;
            $display("FAIL drain_timeout left=%0d", mbuf.size());
        end
        for (int k = 0; k < 3; k++)
            step(0, 16'h0, 16'h0, 0, 0, 0, 1);
    endtask

    always @(posedge mclk) begin
        logic [31:0] e;
        #1;
        if (rd_ack) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected act=%h exp=none", rd_data);
            end else begin
                e = expq.pop_front();
                if (rd_data !== e) begin
                    bad++;
                    $display("FAIL rd_data act=%h exp=%h", rd_data, e);
                end
            end
            last_rd = rd_data;
            if (prev_ack) begin
                total++; bad++;
                $display("FAIL rd_ack_back2back act=1 exp=0");
            end
        end
        prev_ack = rd_ack;
    end

    initial begin
        bit irq_r;
        repeat (2) @(posedge mclk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        @(negedge mclk);
        puc_rst_n = 1'b1;

        // 5 untriggered captures read back in order
        cfg_trig_en = 0;
        step(0, 16'h0, 16'h0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++)
            step(1, 16'hF000 + 16'(2 * k), 16'h4000 + 16'(k), 0, 0, 0, 0);
        step(0, 16'h0, 16'h0, 0, 0, 1, 0);
        chk("t1_count", 32'(count), 32'd5);
        drain();
        chk("t1_last_pc", 32'(last_rd[31:16]), 32'hF008);
        chk("t1_empty", 32'(rd_empty), 32'd1);

        // async reset in the middle of POST
        cfg_trig_en = 1; cfg_trig_pc = 16'h0300; cfg_post_cnt = 5'd5;
        step(0, 16'h0, 16'h0, 0, 1, 0, 0);
        step(1, 16'h0300, 16'h1111, 0, 0, 0, 0);
        step(1, 16'h0302, 16'h2222, 0, 0, 0, 0);
        chk("pre_rst_post", 32'(state), 32'd2);
        #3;
        puc_rst_n = 1'b0;
        #1;
        chk("rst_mid_state", 32'(state), 32'd0);
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_trig", 32'(trig_hit), 32'd0);
        chk("rst_mid_ack", 32'(rd_ack), 32'd0);
        chk("rst_mid_data", rd_data, 32'd0);
        model_reset();
        @(negedge mclk);
        @(negedge mclk);
        puc_rst_n = 1'b1;

        // wraparound: 20 captures keep the newest 16
        cfg_trig_en = 0;
        step(0, 16'h0, 16'h0, 0, 1, 0, 0);
        for (int k = 0; k < 20; k++)
            step(1, 16'h0100 + 16'(2 * k), 16'(k), 0, 0, 0, 0);
        step(0, 16'h0, 16'h0, 0, 0, 1, 0);
        chk("t2_count", 32'(count), 32'd16);
        step(0, 16'h0, 16'h0, 0, 0, 0, 1);
        idle_step();
        chk("t2_first_pc", 32'(last_rd[31:16]), 32'h0108);
        drain();

        // PC trigger with 3 post entries
        cfg_trig_en = 1; cfg_trig_pc = 16'hC010; cfg_post_cnt = 5'd3;
        step(0, 16'h0, 16'h0, 0, 1, 0, 0);
        for (int k = 0; k < 17; k++)
            step(1, 16'hC000 + 16'(2 * k), 16'h3C00 + 16'(k), 0, 0, 0, 0);
        chk("t3_trig", 32'(trig_hit), 32'd1);
        chk("t3_state", 32'(state), 32'd3);
        chk("t3_count", 32'(count), 32'd12);
        drain();
        chk("t3_last_pc", 32'(last_rd[31:16]), 32'hC016);

        // zero post count, then arm+stop together in DONE
        cfg_trig_pc = 16'h0400; cfg_post_cnt = 5'd0;
        step(0, 16'h0, 16'h0, 0, 1, 0, 0);
        step(1, 16'h0400, 16'h9999, 0, 0, 0, 0);
        chk("t4_state", 32'(state), 32'd3);
        chk("t4_count", 32'(count), 32'd1);
        step(1, 16'h0400, 16'h9999, 0, 1, 1, 0);
        chk("t4_arm_state", 32'(state), 32'd1);
        chk("t4_arm_count", 32'(count), 32'd0);

        // IRQ entry filtering
        cfg_trig_en = 0;
        step(0, 16'h0, 16'h0, 0, 1, 0, 0);
        step(1, 16'h0500, 16'h1, 0, 0, 0, 0);
        step(1, 16'hFFFE, 16'h2, 1, 0, 0, 0);
        step(1, 16'h0502, 16'h3, 0, 0, 0, 0);
        step(0, 16'h0, 16'h0, 0, 0, 1, 0);
`ifdef PU_MSP430_TRACE_IRQ_FILTER_EN
        chk("t5_irq_count", 32'(count), 32'd2);
`else
        chk("t5_irq_count", 32'(count), 32'd3);
`endif
        drain();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit a;
            if ($urandom_range(0, 39) == 0) begin
                cfg_trig_en  = 1'($urandom_range(0, 1));
                cfg_trig_pc  = 16'h0200 + 16'(2 * $urandom_range(0, 15));
                cfg_post_cnt = 5'($urandom_range(0, 16));
                a = 1;
            end else begin
                a = 0;
            end
            irq_r = ($urandom_range(0, 3) == 0);
            step(1'($urandom_range(0, 1)),
                 16'h0200 + 16'(2 * $urandom_range(0, 15)),
                 16'($urandom),
                 irq_r, a,
                 ($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 1)));
        end
        drain();
        chk("scoreboard_empty", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
